led_page_sched: RTL and testbench

Display-page scheduler between the SoC debug outputs and the 4×8 multiplexed LED display on the iCEFUN board. Time-shares the single display among four information pages (status, live instruction, frozen instruction snapshot, instruction-change counter), rotating on a millisecond timer or jumping on request. Drives the display's `leds1..leds4` column patterns and `leds_pwm` brightness; sits between `soc` and `led_display` in the board top.

---
 rtl/led_page_pkg.sv | 21 ++
 rtl/led_tick_gen.sv | 34 +++
 rtl/led_page_sched.sv | 147 ++++++++++++++
 tb/tb_led_page_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_page_pkg.sv
// Shared constants and helpers for the LED display page scheduler.
// Page indices, PWM ceiling and the status-page column packing.
package led_page_pkg;

  localparam logic [1:0] PAGE_STATUS = 2'd0;
  localparam logic [1:0] PAGE_LIVE   = 2'd1;
  localparam logic [1:0] PAGE_SNAP   = 2'd2;
  localparam logic [1:0] PAGE_COUNT  = 2'd3;

  localparam logic [2:0] PWM_MAX = 3'b111;

  // Status page packed as {leds4, leds3, leds2, leds1}; column 1 bit 1 is a heartbeat "on" dot.
  function automatic logic [31:0] status_word(input logic [3:0] soc_leds,
                                              input logic [6:0] dbg);
    return {5'b0, dbg[6], dbg[2], soc_leds[3],
            5'b0, dbg[5], dbg[1], soc_leds[2],
            5'b0, dbg[4], dbg[0], soc_leds[1],
            5'b0, dbg[3], 1'b1,   soc_leds[0]};
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running millisecond prescaler: ms_tick is high for one cycle
// every CLK_HZ/1000 clocks, decoded from the registered count.
module led_tick_gen #(
  parameter int CLK_HZ = 12_000_000
) (
  input  logic clk,
  input  logic resetn,
  output logic ms_tick
);

  localparam int DIV   = CLK_HZ / 1000;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign ms_tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (ms_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_page_sched.sv
// Time-shares the 4x8 LED display among status/live/snapshot/change-count pages.
// Optional brightness ramp on page entry: define LED_PAGE_FADE_EN.
module led_page_sched
  import led_page_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int PAGE_MS = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  soc_leds,
  input  logic [6:0]  dbg,
  input  logic [31:0] instr_dbg,
  input  logic        hold,
  input  logic        sel_valid,
  input  logic [1:0]  sel_page,
  output logic [7:0]  leds1,
  output logic [7:0]  leds2,
  output logic [7:0]  leds3,
  output logic [7:0]  leds4,
  output logic [2:0]  leds_pwm,
  output logic [1:0]  page,
  output logic        page_strobe
);

  localparam int TMR_W = (PAGE_MS > 1) ? $clog2(PAGE_MS) : 1;

  logic             ms_tick;
  logic             entry;
  logic [1:0]       page_q, page_d;
  logic             page_strobe_q;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [31:0]      snap_q, snap_d;
  logic [31:0]      prev_instr_q;
  logic             prev_vld_q;
  logic [31:0]      chg_cnt_q, chg_cnt_d;
  logic [31:0]      disp_q, disp_d;

  led_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .ms_tick(ms_tick)
  );

  // A jump wins over both hold and the timer; hold only freezes the timer.
  always_comb begin
    page_d = page_q;
    tmr_d  = tmr_q;
    entry  = 1'b0;
    if (sel_valid) begin
      page_d = sel_page;
      tmr_d  = '0;
      entry  = 1'b1;
    end else if (ms_tick && !hold) begin
      if (tmr_q == TMR_W'(PAGE_MS - 1)) begin
        page_d = page_q + 2'd1;
        tmr_d  = '0;
        entry  = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_comb begin
    snap_d = snap_q;
    if (entry && (page_d == PAGE_SNAP)) begin
      snap_d = instr_dbg;
    end
  end

  // prev_vld_q masks the first post-reset cycle, when prev_instr_q is not a real sample.
  always_comb begin
    chg_cnt_d = chg_cnt_q;
    if (prev_vld_q && (instr_dbg != prev_instr_q) && (chg_cnt_q != 32'hFFFF_FFFF)) begin
      chg_cnt_d = chg_cnt_q + 32'd1;
    end
  end

  always_comb begin
    disp_d = '0;
    case (page_q)
      PAGE_STATUS: disp_d = status_word(soc_leds, dbg);
      PAGE_LIVE:   disp_d = instr_dbg;
      PAGE_SNAP:   disp_d = snap_q;
      PAGE_COUNT:  disp_d = chg_cnt_q;
      default:     disp_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      page_q        <= PAGE_STATUS;
      page_strobe_q <= 1'b0;
      tmr_q         <= '0;
      snap_q        <= '0;
      prev_instr_q  <= '0;
      prev_vld_q    <= 1'b0;
      chg_cnt_q     <= '0;
      disp_q        <= '0;
    end else begin
      page_q        <= page_d;
      page_strobe_q <= entry;
      tmr_q         <= tmr_d;
      snap_q        <= snap_d;
      prev_instr_q  <= instr_dbg;
      prev_vld_q    <= 1'b1;
      chg_cnt_q     <= chg_cnt_d;
      disp_q        <= disp_d;
    end
  end

`ifdef LED_PAGE_FADE_EN
  logic [2:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = pwm_q;
    if (entry) begin
      pwm_d = 3'd0;
    end else if (ms_tick && (pwm_q != PWM_MAX)) begin
      pwm_d = pwm_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_q <= PWM_MAX;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign leds_pwm = pwm_q;
`else
  assign leds_pwm = PWM_MAX;
`endif

  assign page        = page_q;
  assign page_strobe = page_strobe_q;
  assign leds1       = disp_q[7:0];
  assign leds2       = disp_q[15:8];
  assign leds3       = disp_q[23:16];
  assign leds4       = disp_q[31:24];

endmodule

// File: tb/tb_led_page_sched.sv
// Directed bench for led_page_sched with a scoreboard of expected values.
// CLK_HZ=4000, PAGE_MS=3: ms tick every 4 cycles, auto-advance every 12 cycles.
module tb_led_page_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  soc_leds;
  logic [6:0]  dbg;
  logic [31:0] instr_dbg;
  logic        hold;
  logic        sel_valid;
  logic [1:0]  sel_page;
  logic [7:0]  leds1, leds2, leds3, leds4;
  logic [2:0]  leds_pwm;
  logic [1:0]  page;
  logic        page_strobe;

  int compared   = 0;
  int mismatched = 0;
  int n_strobe;
  int left;
  logic [2:0] last_pwm;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  led_page_sched #(
    .CLK_HZ (4000),
    .PAGE_MS(3)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soc_leds   (soc_leds),
    .dbg        (dbg),
    .instr_dbg  (instr_dbg),
    .hold       (hold),
    .sel_valid  (sel_valid),
    .sel_page   (sel_page),
    .leds1      (leds1),
    .leds2      (leds2),
    .leds3      (leds3),
    .leds4      (leds4),
    .leds_pwm   (leds_pwm),
    .page       (page),
    .page_strobe(page_strobe)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      e.tag = "sb_empty";
      e.exp = 'x;
    end else begin
      e = sb_q.pop_front();
    end
    compared++;
    assert (obs === e.exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
    $display("check %-12s observed=%h expected=%h", e.tag, obs, e.exp);
  endtask

  task automatic flush_sb(input string tag);
    left = sb_q.size();
    compared++;
    assert (left === 0) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=0 leftover expectations", tag, left);
    end
    sb_q.delete();
  endtask

  initial begin
    resetn    = 1'b0;
    soc_leds  = 4'hA;
    dbg       = 7'h7F;
    instr_dbg = 32'h0;
    hold      = 1'b0;
    sel_valid = 1'b0;
    sel_page  = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    push("rst_page", 32'd0);     check(32'(page));
    push("rst_strobe", 32'd0);   check(32'(page_strobe));
    push("rst_leds", 32'd0);     check({leds4, leds3, leds2, leds1});
    push("rst_pwm", 32'd7);      check(32'(leds_pwm));
    resetn = 1'b1;

    // Status page after first edge
    push("st_leds1", 32'h06);
    push("st_leds2", 32'h07);
    push("st_leds3", 32'h06);
    push("st_leds4", 32'h07);
    push("st_page", 32'd0);
    @(posedge clk); #1;
    check(32'(leds1)); check(32'(leds2)); check(32'(leds3)); check(32'(leds4));
    check(32'(page));

    // Free run: advances at cycles 12, 24, 36, 48
    push("adv_cyc", 32'd12); push("adv_page", 32'd1);
    push("adv_cyc", 32'd24); push("adv_page", 32'd2);
    push("adv_cyc", 32'd36); push("adv_page", 32'd3);
    push("adv_cyc", 32'd48); push("adv_page", 32'd0);
    n_strobe = 0;
    for (int cyc = 2; cyc <= 48; cyc++) begin
      @(posedge clk); #1;
      if (page_strobe) begin
        n_strobe++;
        check(32'(cyc));
        check(32'(page));
      end
    end
    flush_sb("adv_left");
    push("adv_nstrobe", 32'd4); check(32'(n_strobe));

    // Jump to snapshot page; snapshot must ignore later instr changes
    @(negedge clk);
    hold      = 1'b1;
    instr_dbg = 32'h1234_5678;
    sel_valid = 1'b1;
    sel_page  = 2'd2;
    push("jmp_page", 32'd2);
    push("jmp_strobe", 32'd1);
    push("snap_word", 32'h1234_5678);
    push("snap_hold", 32'h1234_5678);
    push("snap_strb0", 32'd0);
    @(posedge clk); #1;
    check(32'(page)); check(32'(page_strobe));
    @(negedge clk);
    sel_valid = 1'b0;
    instr_dbg = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check({leds4, leds3, leds2, leds1});
    repeat (3) @(posedge clk); #1;
    check({leds4, leds3, leds2, leds1});
    check(32'(page_strobe));

    // Asynchronous reset mid-operation
    @(negedge clk);
    resetn    = 1'b0;
    instr_dbg = 32'hAAAA_AAAA;
    #1;
    push("mrst_page", 32'd0);  check(32'(page));
    push("mrst_leds", 32'd0);  check({leds4, leds3, leds2, leds1});
    @(negedge clk);
    resetn = 1'b1;

    // Change counter: first post-reset cycle must not count, then 5 toggles
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      instr_dbg = instr_dbg ^ 32'h1;
      @(negedge clk);
    end
    sel_valid = 1'b1;
    sel_page  = 2'd3;
    push("cnt_strobe", 32'd1);
    push("cnt_word", 32'h0000_0005);
    @(posedge clk); #1;
    check(32'(page_strobe));
    @(negedge clk);
    sel_valid = 1'b0;
    @(posedge clk); #1;
    check({leds4, leds3, leds2, leds1});

    // Saturation: preload near max, then toggle past it
    @(negedge clk);
    force dut.chg_cnt_q = 32'hFFFF_FFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.chg_cnt_q;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr_dbg = instr_dbg ^ 32'h1;
    end
    push("cnt_sat", 32'hFFFF_FFFF);
    repeat (3) @(posedge clk); #1;
    check({leds4, leds3, leds2, leds1});

    // Hold on page 1 for 40 cycles
    @(negedge clk);
    sel_valid = 1'b1;
    sel_page  = 2'd1;
    @(negedge clk);
    sel_valid = 1'b0;
    n_strobe  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (page_strobe) n_strobe++;
    end
    push("hold_page", 32'd1);    check(32'(page));
    push("hold_nstrb", 32'd0);   check(32'(n_strobe));

    // Live page, one-cycle latency
    @(negedge clk);
    instr_dbg = 32'hCAFE_F00D;
    push("live_word", 32'hCAFE_F00D);
    @(posedge clk); #1;
    check({leds4, leds3, leds2, leds1});

    // Jump during hold to page 0, then jump to the same page
    @(negedge clk);
    sel_valid = 1'b1;
    sel_page  = 2'd0;
    push("hjmp_page", 32'd0);
    push("hjmp_strobe", 32'd1);
    push("hjmp_status", 32'h0706_0706);
    @(posedge clk); #1;
    check(32'(page)); check(32'(page_strobe));
    @(negedge clk);
    sel_valid = 1'b0;
    @(posedge clk); #1;
    check({leds4, leds3, leds2, leds1});
    @(negedge clk);
    sel_valid = 1'b1;
    sel_page  = 2'd0;
    push("same_strobe", 32'd1);
    push("same_page", 32'd0);
    @(posedge clk); #1;
    check(32'(page_strobe)); check(32'(page));
    @(negedge clk);
    sel_valid = 1'b0;

    // Brightness after entry
`ifdef LED_PAGE_FADE_EN
    push("fade_start", 32'd0);
    check(32'(leds_pwm));
    last_pwm = leds_pwm;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (leds_pwm != last_pwm) begin
        push("fade_step", 32'(3'(last_pwm + 3'd1)));
        check(32'(leds_pwm));
        last_pwm = leds_pwm;
      end
    end
    push("fade_end", 32'd7);
    check(32'(leds_pwm));
`else
    last_pwm = 3'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    push("pwm_const", 32'd7);
    check(32'(leds_pwm));
`endif

    flush_sb("end_left");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
